// File: rtl/x_move_driver.sv
// Autonomous X player for the tic-tac-toe core: picks a legal square,
// strobes it on xin/Go and waits for the core to commit it.
module x_move_driver #(
  parameter int GO_WIDTH    = 1,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [8:0] xin_star,
  input  logic [8:0] oin_star,
  input  logic       playing_game,
  input  logic       bad_move,
  input  logic       win_game,
  input  logic       lose_game,
  input  logic       draw_game,
  output logic [8:0] xin,
  output logic       Go,
  output logic       busy,
  output logic [3:0] move_cnt,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, WAIT_TURN, SETUP, PULSE, WAIT_ACK, DONE
  } state_t;

  localparam logic [2:0] PW_LAST  = 3'(GO_WIDTH - 1);
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  function automatic logic [8:0] line_mask(input int i);
    logic [8:0] m;
    case (i)
      0:       m = 9'b111_000_000;
      1:       m = 9'b000_111_000;
      2:       m = 9'b000_000_111;
      3:       m = 9'b100_100_100;
      4:       m = 9'b010_010_010;
      5:       m = 9'b001_001_001;
      6:       m = 9'b100_010_001;
      default: m = 9'b001_010_100;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] pop9(input logic [8:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) n = n + {3'b0, v[i]};
    return n;
  endfunction

  // First line holding two of 'own' plus an empty cell; returns that cell.
  function automatic logic [8:0] two_in_line(
    input logic [8:0] own,
    input logic [8:0] occ
  );
    logic [8:0] m;
    logic       hit;
    m   = '0;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!hit && pop9(own & line_mask(i)) == 4'd2 &&
          (line_mask(i) & ~occ) != 9'd0) begin
        m   = line_mask(i) & ~occ;
        hit = 1'b1;
      end
    end
    return m;
  endfunction

  state_t     r_state, w_state_n;
  logic [8:0] r_xin, w_xin_n;
  logic       r_go, w_go_n;
  logic       r_busy, w_busy_n;
  logic [3:0] r_cnt, w_cnt_n;
  logic       r_err, w_err_n;
  logic [7:0] r_tmo, w_tmo_n;
  logic [2:0] r_pw, w_pw_n;

  logic [8:0] w_occ, w_win, w_blk, w_move;
  logic       w_over, w_xturn, w_ack;

  assign w_occ   = xin_star | oin_star;
  assign w_win   = two_in_line(xin_star, w_occ);
  assign w_blk   = two_in_line(oin_star, w_occ);
  assign w_over  = win_game | lose_game | draw_game;
  assign w_xturn = playing_game & ~w_over &
                   (pop9(xin_star) == pop9(oin_star));
  assign w_ack   = (xin_star & r_xin) != 9'd0;

  always_comb begin
    w_move = '0;
    if      (w_win != 9'd0) w_move = w_win;
    else if (w_blk != 9'd0) w_move = w_blk;
    else if (!w_occ[4])     w_move = 9'b000_010_000;
    else if (!w_occ[8])     w_move = 9'b100_000_000;
    else if (!w_occ[6])     w_move = 9'b001_000_000;
    else if (!w_occ[2])     w_move = 9'b000_000_100;
    else if (!w_occ[0])     w_move = 9'b000_000_001;
    else if (!w_occ[7])     w_move = 9'b010_000_000;
    else if (!w_occ[5])     w_move = 9'b000_100_000;
    else if (!w_occ[3])     w_move = 9'b000_001_000;
    else if (!w_occ[1])     w_move = 9'b000_000_010;
  end

  always_comb begin
    w_state_n = r_state;
    w_xin_n   = r_xin;
    w_go_n    = 1'b0;
    w_cnt_n   = r_cnt;
    w_err_n   = r_err;
    w_tmo_n   = r_tmo;
    w_pw_n    = r_pw;
    if (!en) begin
      w_state_n = IDLE;
      w_xin_n   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_n = WAIT_TURN;
          w_cnt_n   = '0;
          w_err_n   = 1'b0;
          w_xin_n   = '0;
        end
        WAIT_TURN: begin
          if (w_over) begin
            w_state_n = DONE;
          end else if (w_xturn) begin
            if (w_move == 9'd0) begin
              w_err_n   = 1'b1;
              w_state_n = DONE;
            end else begin
              w_xin_n   = w_move;
              w_state_n = SETUP;
            end
          end
        end
        SETUP: begin
          w_state_n = PULSE;
          w_go_n    = 1'b1;
          w_pw_n    = '0;
        end
        PULSE: begin
          if (r_pw == PW_LAST) begin
            w_state_n = WAIT_ACK;
            w_tmo_n   = '0;
          end else begin
            w_go_n = 1'b1;
            w_pw_n = r_pw + 3'd1;
          end
        end
        WAIT_ACK: begin
          // A commit seen together with bad_move still counts as accepted.
          if (w_ack) begin
            w_cnt_n   = (r_cnt == 4'd5) ? r_cnt : r_cnt + 4'd1;
            w_xin_n   = '0;
            w_state_n = WAIT_TURN;
          end else if (bad_move || r_tmo == TMO_LAST) begin
            w_err_n   = 1'b1;
            w_xin_n   = '0;
            w_state_n = DONE;
          end else begin
            w_tmo_n = r_tmo + 8'd1;
          end
        end
        DONE: begin
          w_xin_n = '0;
        end
        default: begin
          w_state_n = IDLE;
          w_xin_n   = '0;
        end
      endcase
    end
    w_busy_n = (w_state_n != IDLE) && (w_state_n != DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_xin   <= '0;
      r_go    <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
      r_pw    <= '0;
    end else begin
      r_state <= w_state_n;
      r_xin   <= w_xin_n;
      r_go    <= w_go_n;
      r_busy  <= w_busy_n;
      r_cnt   <= w_cnt_n;
      r_err   <= w_err_n;
      r_tmo   <= w_tmo_n;
      r_pw    <= w_pw_n;
    end
  end

  assign xin      = r_xin;
  assign Go       = r_go;
  assign busy     = r_busy;
  assign move_cnt = r_cnt;
  assign err      = r_err;

endmodule
